// File: rtl/serving_pkg.sv
// serving_pkg: types and helpers shared by the serving RAM arbiter.
// Holds the read-owner encoding and the flat per-channel bus slicing helper.
package serving_pkg;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_CORE = 2'd1,
        OWN_EXT  = 2'd2
    } owner_e;

    localparam int MAX_NCH = 8;

    // Lowest bit of channel ch in a flat bus of width-bit fields.
    function automatic int chan_lo(input int ch, input int width);
        return ch * width;
    endfunction

endpackage

// File: rtl/serving_rr_arb.sv
// serving_rr_arb: combinational round-robin picker over NCH eligible hosts.
// Picks the first eligible channel at or after i_rr_ptr, modulo NCH.
module serving_rr_arb
    import serving_pkg::*;
#(
    parameter int NCH = 2,
    parameter int PW  = 1
) (
    input  logic [NCH-1:0] i_elig,
    input  logic [PW-1:0]  i_rr_ptr,
    output logic [NCH-1:0] o_gnt,
    output logic [PW-1:0]  o_gnt_idx
);

    localparam logic [PW:0] NCH_W = (PW + 1)'(NCH);

    logic [2*NCH-1:0] dbl;
    logic [NCH-1:0]   rot;
    logic [PW:0]      sum;

    // Rotate so bit 0 is the channel at rr_ptr; lowest set bit wins.
    always_comb begin
        dbl       = {i_elig, i_elig} >> i_rr_ptr;
        rot       = dbl[NCH-1:0];
        sum       = '0;
        o_gnt     = '0;
        o_gnt_idx = '0;
        for (int k = NCH - 1; k >= 0; k--) begin
            if (rot[k]) begin
                sum = (PW + 1)'(i_rr_ptr) + (PW + 1)'(k);
                if (sum >= NCH_W) begin
                    sum = sum - NCH_W;
                end
                o_gnt     = NCH'(1) << sum;
                o_gnt_idx = sum[PW-1:0];
            end
        end
    end

endmodule

// File: rtl/serving_ram_arb.sv
// serving_ram_arb: core-priority SRAM arbiter with round-robin host slots.
// Define SERVING_RAM_ARB_STARVE_EN to enable the host starvation guard (o_core_halt).
module serving_ram_arb
    import serving_pkg::*;
#(
    parameter int  DW       = 8,
    parameter int  DEPTH    = 1024,
    parameter int  NCH      = 2,
    parameter int  MAX_WAIT = 64,
    localparam int AW       = $clog2(DEPTH)
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [AW-1:0]     i_core_waddr,
    input  logic [DW-1:0]     i_core_wdata,
    input  logic              i_core_wen,
    input  logic [AW-1:0]     i_core_raddr,
    input  logic              i_core_ren,
    output logic [DW-1:0]     o_core_rdata,
    input  logic [NCH-1:0]    i_ext_req,
    input  logic [NCH-1:0]    i_ext_we,
    input  logic [NCH*AW-1:0] i_ext_adr,
    input  logic [NCH*DW-1:0] i_ext_wdata,
    output logic [NCH-1:0]    o_ext_ack,
    output logic [DW-1:0]     o_ext_rdata,
    output logic [AW-1:0]     o_sram_waddr,
    output logic [DW-1:0]     o_sram_wdata,
    output logic              o_sram_wen,
    output logic [AW-1:0]     o_sram_raddr,
    output logic              o_sram_ren,
    input  logic [DW-1:0]     i_sram_rdata,
    output logic              o_core_halt
);

    localparam int            PW      = (NCH > 1) ? $clog2(NCH) : 1;
    localparam logic [PW-1:0] LAST_CH = PW'(NCH - 1);

    logic [NCH-1:0] elig;
    logic [NCH-1:0] gnt;
    logic [PW-1:0]  gnt_idx;
    logic           gnt_any;
    logic           gnt_we;
    logic [AW-1:0]  gnt_adr;
    logic [DW-1:0]  gnt_wdata;

    logic [PW-1:0]  rr_q, rr_d;
    logic [NCH-1:0] pend_q, pend_d;
    owner_e         own_q, own_d;

    // A host may only use the port the core leaves idle this cycle.
    always_comb begin
        elig = '0;
        for (int c = 0; c < NCH; c++) begin
            elig[c] = i_ext_req[c] & ~pend_q[c] &
                      (i_ext_we[c] ? ~i_core_wen : ~i_core_ren);
        end
    end

    serving_rr_arb #(
        .NCH (NCH),
        .PW  (PW)
    ) u_rr (
        .i_elig    (elig),
        .i_rr_ptr  (rr_q),
        .o_gnt     (gnt),
        .o_gnt_idx (gnt_idx)
    );

    always_comb begin
        gnt_any   = |gnt;
        gnt_we    = |(gnt & i_ext_we);
        gnt_adr   = '0;
        gnt_wdata = '0;
        for (int c = 0; c < NCH; c++) begin
            if (gnt[c]) begin
                gnt_adr   = i_ext_adr[chan_lo(c, AW) +: AW];
                gnt_wdata = i_ext_wdata[chan_lo(c, DW) +: DW];
            end
        end
    end

    always_comb begin
        o_sram_wen   = 1'b0;
        o_sram_waddr = '0;
        o_sram_wdata = '0;
        if (i_core_wen) begin
            o_sram_wen   = 1'b1;
            o_sram_waddr = i_core_waddr;
            o_sram_wdata = i_core_wdata;
        end else if (gnt_any && gnt_we) begin
            o_sram_wen   = 1'b1;
            o_sram_waddr = gnt_adr;
            o_sram_wdata = gnt_wdata;
        end
    end

    always_comb begin
        o_sram_ren   = 1'b0;
        o_sram_raddr = '0;
        if (i_core_ren) begin
            o_sram_ren   = 1'b1;
            o_sram_raddr = i_core_raddr;
        end else if (gnt_any && !gnt_we) begin
            o_sram_ren   = 1'b1;
            o_sram_raddr = gnt_adr;
        end
    end

    always_comb begin
        rr_d   = rr_q;
        pend_d = gnt;
        own_d  = OWN_NONE;
        if (gnt_any) begin
            rr_d = (gnt_idx == LAST_CH) ? '0 : gnt_idx + 1'b1;
        end
        if (i_core_ren) begin
            own_d = OWN_CORE;
        end else if (gnt_any && !gnt_we) begin
            own_d = OWN_EXT;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            rr_q   <= '0;
            pend_q <= '0;
            own_q  <= OWN_NONE;
        end else begin
            rr_q   <= rr_d;
            pend_q <= pend_d;
            own_q  <= own_d;
        end
    end

    // The ack is the pending flag itself: it lives exactly one cycle.
    assign o_ext_ack    = pend_q;
    assign o_core_rdata = (own_q == OWN_CORE) ? i_sram_rdata : '0;
    assign o_ext_rdata  = (own_q == OWN_EXT) ? i_sram_rdata : '0;

`ifdef SERVING_RAM_ARB_STARVE_EN
    localparam int            CW   = $clog2(MAX_WAIT + 1);
    localparam logic [CW-1:0] CMAX = CW'(MAX_WAIT);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          halt_q, halt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (gnt_any) begin
            cnt_d = '0;
        end else if (|i_ext_req && cnt_q != CMAX) begin
            cnt_d = cnt_q + 1'b1;
        end
        halt_d = (cnt_d == CMAX);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            cnt_q  <= '0;
            halt_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            halt_q <= halt_d;
        end
    end

    assign o_core_halt = halt_q;
`else
    // Without the guard the core is never stalled; MAX_WAIT has no effect.
    assign o_core_halt = (MAX_WAIT < 0);
`endif

endmodule
